interval_timer_ctrl: RTL

//   Programmable interval timer controller that sequences a down-counting period counter through a prescaler.

---
 rtl/timer_pkg.sv | 12 +
 rtl/timer_prescaler.sv | 28 ++
 rtl/interval_timer_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the interval timer controller.
package timer_pkg;

  typedef enum logic [1:0] {
    TIMER_IDLE = 2'd0,
    TIMER_RUN  = 2'd1,
    TIMER_DONE = 2'd2
  } timer_state_t;

  localparam int TIMER_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/timer_prescaler.sv
// Clock-enable generator: counts 0..Divisor while enabled and ticks on the last count.
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  Clear,
  input  logic [PRESCALE_W-1:0] Divisor,
  output logic                  Tick
);

  logic [PRESCALE_W-1:0] cnt;

  // A clear restarts the count, so the tick in that cycle is suppressed.
  assign Tick = Enable && !Clear && (cnt == Divisor);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (Clear || !Enable || Tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: prescaled down-counter, one-shot/periodic, sticky Irq.
// Optional capture register enabled by defining INTERVAL_TIMER_CAPTURE_EN.
//
// state      | meaning
// TIMER_IDLE | stopped, configuration accepted, Count holds
// TIMER_RUN  | counting down on prescaler ticks
// TIMER_DONE | one-shot period expired, configuration accepted
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH      = TIMER_DEFAULT_WIDTH,
  parameter int PRESCALE_W = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  CfgWrite,
  input  logic [WIDTH-1:0]      CfgLoad,
  input  logic [PRESCALE_W-1:0] CfgPrescale,
  input  logic                  CfgPeriodic,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic                  IrqAck,
  output logic [WIDTH-1:0]      Count,
  output logic                  Busy,
  output logic                  Expired,
  output logic                  Irq,
  output logic                  CfgErr
`ifdef INTERVAL_TIMER_CAPTURE_EN
  ,
  input  logic                  Capture,
  output logic [WIDTH-1:0]      CaptureVal
`endif
);

  timer_state_t          state, state_nxt;
  logic [WIDTH-1:0]      count_nxt;
  logic [WIDTH-1:0]      load_reg, load_nxt;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_nxt;
  logic                  periodic_reg, periodic_nxt;
  logic                  expired_nxt, irq_nxt, cfgerr_nxt;
  logic                  running, restart, tick, terminal;

  assign running  = (state == TIMER_RUN);
  // Stop dominates Start, so only an unopposed Start resets the prescaler.
  assign restart  = Start && !Stop;
  assign terminal = tick && (Count == '0);
  assign Busy     = running;

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (running),
    .Clear   (restart),
    .Divisor (prescale_reg),
    .Tick    (tick)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= TIMER_IDLE;
      Count        <= '0;
      load_reg     <= '0;
      prescale_reg <= '0;
      periodic_reg <= 1'b0;
      Expired      <= 1'b0;
      Irq          <= 1'b0;
      CfgErr       <= 1'b0;
    end else begin
      state        <= state_nxt;
      Count        <= count_nxt;
      load_reg     <= load_nxt;
      prescale_reg <= prescale_nxt;
      periodic_reg <= periodic_nxt;
      Expired      <= expired_nxt;
      Irq          <= irq_nxt;
      CfgErr       <= cfgerr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = Count;
    load_nxt     = load_reg;
    prescale_nxt = prescale_reg;
    periodic_nxt = periodic_reg;
    expired_nxt  = 1'b0;
    cfgerr_nxt   = 1'b0;
    irq_nxt      = Irq;

    // Set has priority over acknowledge.
    if (IrqAck) irq_nxt = 1'b0;
    if (terminal) irq_nxt = 1'b1;

    case (state)
      TIMER_IDLE, TIMER_DONE: begin
        if (CfgWrite) begin
          load_nxt     = CfgLoad;
          prescale_nxt = CfgPrescale;
          periodic_nxt = CfgPeriodic;
        end
        if (restart) begin
          state_nxt = TIMER_RUN;
          count_nxt = CfgWrite ? CfgLoad : load_reg;
        end
      end
      TIMER_RUN: begin
        if (CfgWrite) cfgerr_nxt = 1'b1;
        if (terminal) expired_nxt = 1'b1;
        if (Stop) begin
          state_nxt = TIMER_IDLE;
        end else if (Start) begin
          count_nxt = load_reg;
        end else if (terminal) begin
          if (periodic_reg) count_nxt = load_reg;
          else              state_nxt = TIMER_DONE;
        end else if (tick) begin
          count_nxt = Count - 1'b1;
        end
      end
      default: begin
        state_nxt = TIMER_IDLE;
      end
    endcase
  end

`ifdef INTERVAL_TIMER_CAPTURE_EN
  // Samples the registered Count, i.e. the value before any same-cycle decrement.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      CaptureVal <= '0;
    end else if (Capture) begin
      CaptureVal <= Count;
    end
  end
`endif

endmodule
